// File: rtl/model_forward_backward_weighting.sv
// Reader side of the DNC temporal link matrix: forward f = L*w or backward b = L'*w.
// Ports: CLK/RST, START/DIRECTION/SIZE_N_IN control, W_IN/L_IN streams, FB_OUT stream, READY.
module model_forward_backward_weighting #(
    parameter int DATA_SIZE  = 64,
    parameter int FRACT_SIZE = 32,
    parameter int MAX_N      = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 DIRECTION,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic                 W_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] W_IN,
    input  logic                 L_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] L_IN,
    output logic                 FB_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] FB_OUT
);

    localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        LOAD_L,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic                 dir_q, dir_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        k_q, k_d;
    logic [IW-1:0]        g_q, g_d;
    logic [IW-1:0]        j_q, j_d;
    logic                 done_q, done_d;
    logic                 pv_q, pv_d;
    logic [IW-1:0]        dst_q, dst_d;
    logic [DATA_SIZE-1:0] p_q, p_d;
    logic                 ready_q, ready_d;
    logic                 en_q, en_d;
    logic [DATA_SIZE-1:0] fb_q, fb_d;

    logic [DATA_SIZE-1:0] w_q   [MAX_N];
    logic [DATA_SIZE-1:0] w_d   [MAX_N];
    logic [DATA_SIZE-1:0] acc_q [MAX_N];
    logic [DATA_SIZE-1:0] acc_d [MAX_N];

    logic                 w_we;
    logic                 acc_clr;
    logic [DATA_SIZE-1:0] n_clamp;
    logic [IW-1:0]        sel;
    logic signed [2*DATA_SIZE-1:0] prod;
    logic                 unused_prod;

    assign n_clamp = (SIZE_N_IN > DATA_SIZE'(MAX_N)) ? DATA_SIZE'(MAX_N)
                                                      : SIZE_N_IN;

    // Forward reads w[j] into acc[g]; backward reads w[g] into acc[j].
    assign sel   = dir_q ? g_q : j_q;
    assign prod  = $signed(L_IN) * $signed(w_q[sel]);
    // Shift right by FRACT_SIZE and truncate is a plain slice of the product.
    assign unused_prod = ^prod;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        last_d  = last_q;
        k_d     = k_q;
        g_d     = g_q;
        j_d     = j_q;
        done_d  = done_q;
        pv_d    = 1'b0;
        dst_d   = dst_q;
        p_d     = p_q;
        ready_d = 1'b0;
        en_d    = 1'b0;
        fb_d    = fb_q;
        w_we    = 1'b0;
        acc_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The READY cycle is spent in IDLE; START is not taken then.
                if (START && !ready_q) begin
                    dir_d   = DIRECTION;
                    last_d  = IW'(n_clamp - DATA_SIZE'(1));
                    k_d     = '0;
                    g_d     = '0;
                    j_d     = '0;
                    done_d  = 1'b0;
                    acc_clr = 1'b1;
                    if (n_clamp == '0) begin
                        ready_d = 1'b1;
                    end else begin
                        state_d = LOAD_W;
                    end
                end
            end
            LOAD_W: begin
                if (W_IN_ENABLE) begin
                    w_we = 1'b1;
                    if (k_q == last_q) begin
                        k_d     = '0;
                        state_d = LOAD_L;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            LOAD_L: begin
                if (L_IN_ENABLE) begin
                    pv_d  = 1'b1;
                    dst_d = dir_q ? j_q : g_q;
                    p_d   = prod[FRACT_SIZE +: DATA_SIZE];
                    if (j_q == last_q) begin
                        j_d = '0;
                        if (g_q == last_q) begin
                            g_d     = '0;
                            state_d = DRAIN;
                        end else begin
                            g_d = g_q + 1'b1;
                        end
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (done_q) begin
                    ready_d = 1'b1;
                    done_d  = 1'b0;
                    k_d     = '0;
                    state_d = IDLE;
                end else if (!pv_q) begin
                    // Wait for the last product to land in acc first.
                    en_d = 1'b1;
                    fb_d = acc_q[k_q];
                    if (k_q == last_q) begin
                        done_d = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_d   = w_q;
        acc_d = acc_q;
        if (w_we) begin
            w_d[k_q] = W_IN;
        end
        if (acc_clr) begin
            for (int i = 0; i < MAX_N; i++) begin
                acc_d[i] = '0;
            end
        end else if (pv_q) begin
            acc_d[dst_q] = acc_q[dst_q] + p_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            last_q  <= '0;
            k_q     <= '0;
            g_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
            pv_q    <= 1'b0;
            dst_q   <= '0;
            p_q     <= '0;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
            k_q     <= k_d;
            g_q     <= g_d;
            j_q     <= j_d;
            done_q  <= done_d;
            pv_q    <= pv_d;
            dst_q   <= dst_d;
            p_q     <= p_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            fb_q    <= fb_d;
        end
    end

    // Storage arrays carry no reset; a new START clears the accumulators.
    always_ff @(posedge CLK) begin
        w_q   <= w_d;
        acc_q <= acc_d;
    end

    assign READY         = ready_q;
    assign FB_OUT_ENABLE = en_q;
    assign FB_OUT        = fb_q;

endmodule

// File: tb/tb_model_forward_backward_weighting.sv
// Directed bench for model_forward_backward_weighting.
// Hand-computed Q32.32 vectors; outputs captured on the falling edge.
module tb_model_forward_backward_weighting;

    localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
    localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic        w_en = 1'b0;
    logic        l_en = 1'b0;
    logic [63:0] size_n = '0;
    logic [63:0] w_in = '0;
    logic [63:0] l_in = '0;
    logic        ready;
    logic        fb_en;
    logic [63:0] fb_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_cnt = 0;
    int last_l_cyc = 0;

    logic [63:0] out_q[$];
    int          out_cyc[$];
    logic [63:0] exp_q[$];

    model_forward_backward_weighting dut (
        .CLK          (clk),
        .RST          (rst),
        .START        (start),
        .READY        (ready),
        .DIRECTION    (dir),
        .SIZE_N_IN    (size_n),
        .W_IN_ENABLE  (w_en),
        .W_IN         (w_in),
        .L_IN_ENABLE  (l_en),
        .L_IN         (l_in),
        .FB_OUT_ENABLE(fb_en),
        .FB_OUT       (fb_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fb_en) begin
            out_q.push_back(fb_out);
            out_cyc.push_back(cyc);
        end
        if (ready) ready_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_start(input logic d, input logic [63:0] n);
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
        start = 1'b1;
        dir = d;
        size_n = n;
        step();
        start = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] v);
        w_en = 1'b1;
        w_in = v;
        step();
        w_en = 1'b0;
    endtask

    task automatic send_l(input logic [63:0] v);
        l_en = 1'b1;
        l_in = v;
        step();
        last_l_cyc = cyc;
        l_en = 1'b0;
    endtask

    task automatic finish_op(input string tag);
        int r0;
        int t;
        r0 = ready_cnt;
        t = 0;
        while (ready_cnt == r0 && t < 300) begin
            step();
            t++;
        end
        idle(3);
        check({tag, "_ready_pulses"}, 64'(ready_cnt - r0), 64'd1);
        check({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_out%0d", tag, i),
                  (i < out_q.size()) ? out_q[i] : 64'hDEAD_BEEF_DEAD_BEEF,
                  exp_q[i]);
        end
    endtask

    initial begin
        int lat;
        logic [63:0] n64;

        @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_en", 64'(fb_en), 64'd0);
        check("rst_out", fb_out, 64'd0);
        rst = 1'b0;
        idle(2);

        // Forward N=2
        do_start(1'b0, 64'd2);
        send_w(ONE);
        send_w(HALF);
        send_l(64'd0);
        send_l(ONE);
        send_l(HALF);
        send_l(64'd0);
        exp_q = '{HALF, HALF};
        finish_op("fwd2");
        lat = (out_cyc.size() > 0) ? out_cyc[0] - last_l_cyc : -1;
        check("fwd2_latency", 64'(lat), 64'd2);
        lat = (out_cyc.size() > 1) ? out_cyc[1] - out_cyc[0] : -1;
        check("fwd2_consecutive", 64'(lat), 64'd1);

        // Backward N=2, same data
        do_start(1'b1, 64'd2);
        send_w(ONE);
        send_w(HALF);
        send_l(64'd0);
        send_l(ONE);
        send_l(HALF);
        send_l(64'd0);
        exp_q = '{64'h4000_0000, ONE};
        finish_op("bwd2");

        // Forward N=3 with gaps and strobes that must be ignored
        do_start(1'b0, 64'd3);
        send_l(64'h7777_0000_0000);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            send_w(ONE);
            idle(1);
        end
        for (int i = 0; i < 9; i++) begin
            send_l(ONE);
            idle(1);
            if (i == 0) send_w(64'h5_0000_0000);
            if (i == 3) begin
                start = 1'b1;
                dir = 1'b1;
                size_n = 64'd1;
                step();
                start = 1'b0;
            end
        end
        exp_q = '{64'h3_0000_0000, 64'h3_0000_0000, 64'h3_0000_0000};
        finish_op("gap3");

        // N=0: READY with no output
        do_start(1'b0, 64'd0);
        finish_op("n0");

        // N=20 clamps to 8: L = 2.0 * I, w[k] = k+1
        do_start(1'b0, 64'd20);
        for (int k = 0; k < 8; k++) send_w(64'(k + 1) << 32);
        for (int g = 0; g < 8; g++)
            for (int j = 0; j < 8; j++)
                send_l((g == j) ? 64'h2_0000_0000 : 64'd0);
        for (int k = 0; k < 8; k++) begin
            n64 = 64'(2 * (k + 1)) << 32;
            exp_q.push_back(n64);
        end
        finish_op("n20");

        // Two's-complement wrap of the accumulator
        do_start(1'b0, 64'd2);
        send_w(ONE);
        send_w(ONE);
        send_l(64'h7000_0000_0000_0000);
        send_l(64'h2000_0000_0000_0000);
        send_l(64'h8000_0000_0000_0000);
        send_l(64'h8000_0000_0000_0000);
        exp_q = '{64'h9000_0000_0000_0000, 64'd0};
        finish_op("wrap");

        // Sign: -1.0 * 2.0
        do_start(1'b0, 64'd1);
        send_w(64'hFFFF_FFFF_0000_0000);
        send_l(64'h2_0000_0000);
        exp_q = '{64'hFFFF_FFFE_0000_0000};
        finish_op("sign");

        // Reset during LOAD_L aborts with no READY
        do_start(1'b0, 64'd2);
        send_w(ONE);
        send_w(ONE);
        send_l(64'h7_0000_0000);
        send_l(64'h9_0000_0000);
        rst = 1'b1;
        #1;
        check("abort_out", fb_out, 64'd0);
        check("abort_en", 64'(fb_en), 64'd0);
        lat = ready_cnt;
        idle(2);
        rst = 1'b0;
        idle(20);
        check("abort_no_ready", 64'(ready_cnt - lat), 64'd0);

        // Fresh run after abort: no residue in the accumulators
        do_start(1'b0, 64'd2);
        send_w(ONE);
        send_w(HALF);
        send_l(64'd0);
        send_l(ONE);
        send_l(HALF);
        send_l(64'd0);
        exp_q = '{HALF, HALF};
        finish_op("after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/model_forward_backward_weighting.md
Name: model_forward_backward_weighting

Overview:
- Reader side of the DNC temporal link matrix. Consumes the streamed link matrix L(t) and the previous read weighting w(t-1).
- Produces the forward weighting f[g] = Σj L[g;j]·w[j] or the backward weighting b[j] = Σg L[g;j]·w[g], selected per operation.
- Sits between the temporal link matrix block and the read weighting block in the DNC memory.
- Arithmetic is signed fixed-point multiply-accumulate, so results are bit-exact and checkable.

Parameters:
- DATA_SIZE, 64, width of every data word (signed two's complement, Q-format).
- FRACT_SIZE, 32, fractional bits of the Q-format; 1.0 = 2^FRACT_SIZE.
- MAX_N, 8, maximum vector length N; sets the depth of the w buffer and the accumulator array.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle strobe; begins an operation when idle.
- READY  out  1  one-cycle pulse when the operation completes.
- DIRECTION  in  1  sampled at START; 0 = forward, 1 = backward.
- SIZE_N_IN  in  DATA_SIZE  vector length N, sampled at START.
- W_IN_ENABLE  in  1  strobe: W_IN is valid this cycle.
- W_IN  in  DATA_SIZE  w(t-1) element, index order 0..N-1.
- L_IN_ENABLE  in  1  strobe: L_IN is valid this cycle.
- L_IN  in  DATA_SIZE  L element, row-major (g outer, j inner).
- FB_OUT_ENABLE  out  1  FB_OUT is valid this cycle.
- FB_OUT  out  DATA_SIZE  weighting element, index order 0..N-1.

Behaviour:
- Reset (asynchronous, whenever RST=1):
  - READY=0, FB_OUT_ENABLE=0, FB_OUT=0, FSM to IDLE, all counters 0.
  - Buffer and accumulator contents are don't-care.
  - Reset mid-operation aborts the operation; no READY is issued.
- FSM states: IDLE, LOAD_W, LOAD_L, DRAIN.
- IDLE:
  - On START=1, latch DIRECTION and N = min(SIZE_N_IN, MAX_N), clear all accumulators, go to LOAD_W.
  - If N=0, go straight to a one-cycle READY pulse and return to IDLE with no output.
  - W/L strobes received in IDLE are ignored.
- LOAD_W:
  - Each W_IN_ENABLE=1 writes w[k]=W_IN and increments k.
  - After the Nth write, go to LOAD_L.
  - L strobes received in LOAD_W are ignored.
- LOAD_L:
  - Each L_IN_ENABLE=1 takes element (g,j) and forms p = (L_IN × w[sel]) as a full 2·DATA_SIZE signed product.
  - p is arithmetically shifted right by FRACT_SIZE and truncated to DATA_SIZE.
  - acc[dst] += p, wrapping modulo 2^DATA_SIZE with no saturation.
  - Forward: sel=j, dst=g. Backward: sel=g, dst=j.
  - j wraps from N-1 to 0 and increments g.
  - After element (N-1,N-1), go to DRAIN.
  - W strobes received in LOAD_L are ignored.
  - Strobes may arrive back-to-back on every cycle, or with arbitrary gaps; gaps cause no state change.
- DRAIN:
  - Outputs are registered. FB_OUT_ENABLE=1 with FB_OUT=acc[k] for N consecutive cycles, k=0..N-1.
  - The first output is valid 2 rising edges after the edge that sampled the last L element.
  - In the cycle after the last output: FB_OUT_ENABLE=0 and READY=1 for exactly one cycle, then IDLE.
  - FB_OUT holds its last value when not enabled.
- START outside IDLE is ignored, including in the READY cycle.
- Throughput: one input element per cycle, one output per cycle. There is no backpressure; the producer must not strobe faster than one element per cycle.
- SIZE_N_IN > MAX_N is clamped to MAX_N; exactly MAX_N w values and MAX_N² L values are then expected.

Test Plan:
- Forward, N=2, Q32.32:
  - Stimulus: w=[1.0,0.5], L=[[0,1.0],[0.5,0]], back-to-back strobes.
  - Required: FB_OUT=[0.5,0.5] (0x80000000 each) on 2 consecutive cycles, then READY one cycle.
- Backward, same data:
  - Required: FB_OUT=[0.25,1.0] (0x40000000, 0x100000000).
- Gapped strobes plus ignored strobes:
  - Stimulus: forward N=3, w=[1,1,1], L=all 1.0, one idle cycle between elements; an L strobe issued during LOAD_W and a START issued during LOAD_L.
  - Required: both are ignored; FB_OUT=[3.0,3.0,3.0].
- Boundary N values:
  - SIZE_N_IN=0 -> READY pulse with no FB_OUT_ENABLE.
  - SIZE_N_IN=20 with MAX_N=8 -> exactly 8 W and 64 L strobes accepted; 8 outputs produced.
- Sign and wrap:
  - Stimulus: w=[-1.0], L=[[2.0]], N=1 -> FB_OUT = -2.0 (0xFFFFFFFE00000000).
  - Stimulus: accumulation past +2^63 -> two's-complement wrap.
- Reset mid-operation:
  - Stimulus: assert RST during LOAD_L.
  - Required: outputs go to 0 immediately and no READY is issued. A new START then completes correctly; the accumulators show no residue from the aborted run.
